// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the
// MEM-stage access and the loader, stalling the core meanwhile.
module dmem_arbiter #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 64,
  parameter  int TIMEOUT = 255,
  localparam int MASK_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [MASK_W-1:0] core_wmask,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CBUSY,
    S_CDONE,
    S_LBUSY,
    S_LDONE
  } state_e;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e              state_q;
  logic                last_ldr_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic [DATA_W-1:0]   crd_q;
  logic [DATA_W-1:0]   lrd_q;
  logic                rvalid_q;
  logic                ldone_q;
  logic                err_q;
  logic [15:0]         cnt_q;
  logic [15:0]         cnt_d;

  logic core_req;
  logic gnt_core;
  logic gnt_ldr;
  logic is_core;
  logic tmo;

  // Round-robin grant and timeout detection for the current cycle
  always_comb begin
    core_req = core_re | core_we;
    gnt_core = core_req & (~ldr_req | last_ldr_q);
    gnt_ldr  = ldr_req & ~gnt_core;
    is_core  = (state_q == S_CBUSY);
    cnt_d    = cnt_q + 16'd1;
    tmo      = (cnt_d == TMO);
  end

  assign core_stall  = core_req & (state_q != S_CDONE);
  assign core_rdata  = crd_q;
  assign core_rvalid = rvalid_q;
  assign ldr_done    = ldone_q;
  assign ldr_rdata   = lrd_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign err         = err_q;

  // Access FSM with registered memory-side and completion outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      last_ldr_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      crd_q       <= '0;
      lrd_q       <= '0;
      rvalid_q    <= 1'b0;
      ldone_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rvalid_q <= 1'b0;
      ldone_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (gnt_core) begin
            state_q     <= S_CBUSY;
            last_ldr_q  <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= core_we;
            mem_addr_q  <= core_addr;
            mem_wdata_q <= core_wdata;
            mem_wmask_q <= core_wmask;
          end else if (gnt_ldr) begin
            state_q     <= S_LBUSY;
            last_ldr_q  <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ldr_we;
            mem_addr_q  <= ldr_addr;
            mem_wdata_q <= ldr_wdata;
            mem_wmask_q <= {MASK_W{ldr_we}};
          end
        end
        S_CBUSY, S_LBUSY: begin
          if (mem_ack || tmo) begin
            mem_req_q <= 1'b0;
            if (is_core) begin
              state_q  <= S_CDONE;
              rvalid_q <= 1'b1;
            end else begin
              state_q <= S_LDONE;
              ldone_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
          if (mem_ack) begin
            if (!mem_we_q) begin
              if (is_core) crd_q <= mem_rdata;
              else         lrd_q <= mem_rdata;
            end
          end else if (tmo) begin
            err_q <= 1'b1;
            if (is_core) crd_q <= '0;
            else         lrd_q <= '0;
          end
        end
        S_CDONE, S_LDONE: state_q <= S_IDLE;
        default:          state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, corner sequences
// and a randomized run against a transaction-level model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int N  = 500;

  localparam logic [63:0] A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] B = 64'h1111_2222_3333_4444;
  localparam logic [63:0] C = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] E = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] F = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] G = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] H = 64'h0F0F_1E1E_2D2D_3C3C;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          core_re = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [MW-1:0] core_wmask = '0;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic          core_rvalid;
  logic          ldr_req = 1'b0;
  logic          ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_done;
  logic [DW-1:0] ldr_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          err;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .core_re    (core_re),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wmask (core_wmask),
    .core_stall (core_stall),
    .core_rdata (core_rdata),
    .core_rvalid(core_rvalid),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_done   (ldr_done),
    .ldr_rdata  (ldr_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .err        (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {63'd0, act}, {63'd0, exp});
  endtask

  function automatic logic [63:0] hash(input logic [31:0] a);
    return {a ^ 32'hA5A5_0F0F, ~a};
  endfunction

  typedef struct {
    logic        re, we, lq, lw, ack;
    logic [31:0] ca;
    logic [7:0]  cm;
    logic [63:0] mrd;
    logic        st, rv, ld, mq, mwe;
    logic [7:0]  mm;
    logic [31:0] ma;
    logic [63:0] crd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic re, we, lq, lw, ack,
    input logic [31:0] ca, input logic [7:0] cm,
    input logic [63:0] mrd,
    input logic st, rv, ld, mq, mwe,
    input logic [7:0] mm, input logic [31:0] ma,
    input logic [63:0] crd);
    vec_t v;
    v.re = re; v.we = we; v.lq = lq; v.lw = lw; v.ack = ack;
    v.ca = ca; v.cm = cm; v.mrd = mrd;
    v.st = st; v.rv = rv; v.ld = ld; v.mq = mq; v.mwe = mwe;
    v.mm = mm; v.ma = ma; v.crd = crd;
    return v;
  endfunction

  // random-phase model state
  bit          c_act, c_we, l_act, l_we, open;
  logic [31:0] c_addr, l_addr, t_addr;
  logic [63:0] c_wdata, l_wdata, t_wdata, c_rd, l_rd;
  logic [7:0]  c_wmask, t_wmask;
  bit          t_we;
  int          dly, own, pend, c_wait, l_wait, l_ncore;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_stall", core_stall, 1'b0);
    chk1("rst_rvalid", core_rvalid, 1'b0);
    chk1("rst_ldone", ldr_done, 1'b0);
    chk1("rst_mreq", mem_req, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_crd", core_rdata, 64'd0);
    chk("rst_lrd", ldr_rdata, 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // tie after reset, loader-owned stall, core load, core store
    tbl.push_back(mk(1,0,1,0,0,'h100,'hFF,0, 1,0,0,0,0,'h00,'h000,0));
    tbl.push_back(mk(1,0,1,0,1,'h100,'hFF,A, 1,0,0,1,0,'hFF,'h100,0));
    tbl.push_back(mk(1,0,1,0,0,'h100,'hFF,0, 0,1,0,0,0,'h00,'h000,A));
    tbl.push_back(mk(1,0,1,0,0,'h100,'hFF,0, 1,0,0,0,0,'h00,'h000,A));
    tbl.push_back(mk(1,0,1,0,1,'h100,'hFF,B, 1,0,0,1,0,'h00,'h000,A));
    tbl.push_back(mk(1,0,1,0,0,'h100,'hFF,0, 1,0,1,0,0,'h00,'h000,A));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 1,0,0,0,0,'h00,'h000,A));
    tbl.push_back(mk(1,0,0,0,1,'h100,'hFF,C, 1,0,0,1,0,'hFF,'h100,A));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 0,1,0,0,0,'h00,'h000,C));
    tbl.push_back(mk(0,0,0,0,0,'h100,'hFF,0, 0,0,0,0,0,'h00,'h000,C));
    tbl.push_back(mk(0,0,1,1,0,'h100,'hFF,0, 0,0,0,0,0,'h00,'h000,C));
    tbl.push_back(mk(1,0,1,1,0,'h100,'hFF,0, 1,0,0,1,1,'hFF,'h000,C));
    tbl.push_back(mk(1,0,1,1,1,'h100,'hFF,D, 1,0,0,1,1,'hFF,'h000,C));
    tbl.push_back(mk(1,0,1,1,0,'h100,'hFF,0, 1,0,1,0,0,'h00,'h000,C));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 1,0,0,0,0,'h00,'h000,C));
    tbl.push_back(mk(1,0,0,0,1,'h100,'hFF,E, 1,0,0,1,0,'hFF,'h100,C));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 0,1,0,0,0,'h00,'h000,E));
    tbl.push_back(mk(0,0,0,0,0,'h100,'hFF,0, 0,0,0,0,0,'h00,'h000,E));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 1,0,0,0,0,'h00,'h000,E));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 1,0,0,1,0,'hFF,'h100,E));
    tbl.push_back(mk(1,0,0,0,1,'h100,'hFF,F, 1,0,0,1,0,'hFF,'h100,E));
    tbl.push_back(mk(1,0,0,0,0,'h100,'hFF,0, 0,1,0,0,0,'h00,'h000,F));
    tbl.push_back(mk(0,0,0,0,0,'h100,'hFF,0, 0,0,0,0,0,'h00,'h000,F));
    tbl.push_back(mk(0,1,0,0,0,'h008,'h0F,0, 1,0,0,0,0,'h00,'h000,F));
    tbl.push_back(mk(0,1,0,0,1,'h008,'h0F,G, 1,0,0,1,1,'h0F,'h008,F));
    tbl.push_back(mk(0,1,0,0,0,'h008,'h0F,0, 0,1,0,0,0,'h00,'h000,F));
    tbl.push_back(mk(0,0,0,0,0,'h008,'h0F,0, 0,0,0,0,0,'h00,'h000,F));
    tbl.push_back(mk(0,0,0,0,0,'h008,'h0F,0, 0,0,0,0,0,'h00,'h000,F));

    core_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    ldr_wdata  = 64'h1234_5678_9ABC_DEF0;
    ldr_addr   = 32'h0;
    foreach (tbl[i]) begin
      @(negedge clk);
      core_re    = tbl[i].re;
      core_we    = tbl[i].we;
      ldr_req    = tbl[i].lq;
      ldr_we     = tbl[i].lw;
      mem_ack    = tbl[i].ack;
      mem_rdata  = tbl[i].mrd;
      core_addr  = tbl[i].ca;
      core_wmask = tbl[i].cm;
      #1;
      chk1($sformatf("t%0d_stall", i), core_stall, tbl[i].st);
      chk1($sformatf("t%0d_rvalid", i), core_rvalid, tbl[i].rv);
      chk1($sformatf("t%0d_ldone", i), ldr_done, tbl[i].ld);
      chk1($sformatf("t%0d_mreq", i), mem_req, tbl[i].mq);
      chk($sformatf("t%0d_crd", i), core_rdata, tbl[i].crd);
      if (tbl[i].mq) begin
        chk1($sformatf("t%0d_mwe", i), mem_we, tbl[i].mwe);
        chk($sformatf("t%0d_mwmask", i), 64'(mem_wmask), 64'(tbl[i].mm));
        chk($sformatf("t%0d_maddr", i), 64'(mem_addr), 64'(tbl[i].ma));
      end
    end
    chk("tbl_lrd", ldr_rdata, B);
    chk1("tbl_err", err, 1'b0);

    // timeout: core load never acked
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = H;
    core_re = 1'b1;
    core_addr = 32'h40;
    begin
      int busy;
      bit got;
      busy = 0;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
        @(negedge clk);
        #1;
        if (mem_req) busy++;
        if (core_rvalid) got = 1'b1;
      end
      chk1("tmo_rvalid", got, 1'b1);
      chk("tmo_busy", 64'(busy), 64'd4);
      chk("tmo_crd", core_rdata, 64'd0);
      chk1("tmo_err", err, 1'b1);
    end
    core_re = 1'b0;

    // acked loader read after timeout leaves err set
    @(negedge clk);
    ldr_req = 1'b1;
    ldr_we  = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        #1;
        if (ldr_done) begin
          got = 1'b1;
          ldr_req = 1'b0;
        end
        mem_ack = mem_req & ~mem_ack;
      end
      chk1("tmo2_done", got, 1'b1);
      chk("tmo2_lrd", ldr_rdata, H);
      chk1("tmo2_err", err, 1'b1);
    end
    mem_ack = 1'b0;

    // reset during CORE_BUSY
    @(negedge clk);
    core_re = 1'b1;
    core_addr = 32'h200;
    @(negedge clk);
    #1;
    chk1("mrst_busy", mem_req, 1'b1);
    nrst = 1'b0;
    #1;
    chk1("mrst_mreq", mem_req, 1'b0);
    chk1("mrst_rvalid", core_rvalid, 1'b0);
    chk1("mrst_err", err, 1'b0);
    @(negedge clk);
    core_re = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk1("mrst_nopulse", core_rvalid, 1'b0);
      chk1("mrst_idle", mem_req, 1'b0);
    end

    // randomized traffic vs transaction model
    c_act = 0; l_act = 0; open = 0; pend = 0;
    c_rd = '0; l_rd = '0; l_ncore = 0;
    c_wait = 0; l_wait = 0;
    for (int i = 0; i < N + 200; i++) begin
      bit dc, dl;
      @(negedge clk);
      #1;
      dc = (pend == 1);
      dl = (pend == 2);
      pend = 0;
      chk1("rnd_rvalid", core_rvalid, dc);
      chk1("rnd_ldone", ldr_done, dl);
      chk1("rnd_stall", core_stall, c_act & ~dc);
      if (dc) begin
        if (!c_we) c_rd = hash(c_addr);
        chk("rnd_crd", core_rdata, c_rd);
        c_act = 0;
        if (l_act) l_ncore++;
      end
      if (dl) begin
        if (!l_we) l_rd = hash(l_addr);
        chk("rnd_lrd", ldr_rdata, l_rd);
        chk1("rnd_starve", l_ncore <= 1, 1'b1);
        l_act = 0;
      end
      // memory responder
      if (mem_ack) begin
        mem_ack = 1'b0;
        open = 0;
      end else if (mem_req) begin
        if (!open) begin
          open = 1;
          t_we = mem_we; t_addr = mem_addr;
          t_wdata = mem_wdata; t_wmask = mem_wmask;
          dly = $urandom_range(0, 2);
          own = 0;
          if (c_act && t_we == c_we && t_addr == c_addr &&
              t_wmask == c_wmask && (!c_we || t_wdata == c_wdata))
            own = 1;
          else if (l_act && t_we == l_we && t_addr == l_addr &&
                   t_wmask == {8{l_we}} &&
                   (!l_we || t_wdata == l_wdata))
            own = 2;
          chk1("rnd_owner", own != 0, 1'b1);
        end else begin
          chk1("rnd_hold", mem_we == t_we && mem_addr == t_addr &&
               mem_wdata == t_wdata && mem_wmask == t_wmask, 1'b1);
        end
        if (dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = hash(mem_addr);
          pend = own;
        end else begin
          dly--;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        mem_rdata = {$urandom, $urandom};
      end
      // core driver
      if (c_act) begin
        c_wait++;
        if (c_wait > 40) begin
          chk1("rnd_core_wait", 1'b0, 1'b1);
          c_act = 0;
        end
      end
      if (!c_act) begin
        core_re = 1'b0;
        core_we = 1'b0;
        if (i < N && $urandom_range(0, 2) == 0) begin
          int op;
          op = $urandom_range(0, 2);
          c_act = 1; c_wait = 0;
          core_re = (op != 1);
          core_we = (op != 0);
          c_we = core_we;
          c_addr = $urandom & 32'h0000_0FF8;
          c_wdata = {$urandom, $urandom};
          c_wmask = 8'($urandom);
          core_addr = c_addr;
          core_wdata = c_wdata;
          core_wmask = c_wmask;
        end
      end
      // loader driver
      if (l_act) begin
        l_wait++;
        if (l_wait > 40) begin
          chk1("rnd_ldr_wait", 1'b0, 1'b1);
          l_act = 0;
        end
      end
      if (!l_act) begin
        ldr_req = 1'b0;
        if (!dl && i < N && $urandom_range(0, 3) == 0) begin
          l_act = 1; l_wait = 0; l_ncore = 0;
          l_we = 1'($urandom);
          l_addr = 32'h0000_1000 | ($urandom & 32'h0000_0FF8);
          l_wdata = {$urandom, $urandom};
          ldr_req = 1'b1;
          ldr_we = l_we;
          ldr_addr = l_addr;
          ldr_wdata = l_wdata;
        end
      end
      if (i >= N && !c_act && !l_act && !open &&
          pend == 0 && !mem_ack) break;
    end
    chk1("rnd_drain", c_act | l_act, 1'b0);
    chk1("rnd_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
